hub75_panel_rx: RTL and testbench

// - Receive end of the HUB75 panel interface: decodes LP_CLK/LATCH/NOE/ROW/RGB0/RGB1 (as driven by led_panel_video) into a pixel write stream.
// - Used as an in-FPGA panel model or loop-back checker. Oversamples the bus on the system clock and rebuilds each latched row pair.
// - Emits one valid/ready pixel per column for the top and bottom half-rows, and measures NOE-low time per line.

---
 rtl/hub75_panel_rx.sv | 157 +++++++++++++++
 tb/tb_hub75_panel_rx.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_panel_rx.sv
// HUB75 receive side: oversamples the panel bus, rebuilds each latched row pair
// and replays it as a valid/ready pixel stream, plus NOE-low time per line.
module hub75_panel_rx #(
  parameter int COLS        = 64,
  parameter int ROW_BITS    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              LP_CLK,
  input  logic                              LATCH,
  input  logic                              NOE,
  input  logic [ROW_BITS-1:0]               ROW,
  input  logic [2:0]                        RGB0,
  input  logic [2:0]                        RGB1,
  output logic                              pix_valid,
  input  logic                              pix_ready,
  output logic [ROW_BITS+$clog2(COLS):0]    pix_addr,
  output logic [2:0]                        pix_rgb,
  output logic                              line_done,
  output logic                              shift_err,
  output logic                              overrun,
  output logic [15:0]                       oe_cycles
);
  localparam int CW  = $clog2(COLS);
  localparam int SCW = CW + 1;
  localparam int IW  = 3 + ROW_BITS + 6;
  localparam logic [SCW-1:0] COLS_C   = SCW'(COLS);
  localparam logic [SCW-1:0] SAT_C    = SCW'(COLS + 1);
  localparam logic [CW-1:0]  LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {IDLE, EMIT_TOP, EMIT_BOT} state_t;

  logic [IW-1:0]       sync_q [SYNC_STAGES];
  logic                lp_s, latch_s, noe_s, lp_d, latch_d, lp_rise, latch_rise;
  logic [ROW_BITS-1:0] row_s, row_l;
  logic [2:0]          rgb0_s, rgb1_s;
  logic [2:0]          sh0 [COLS];
  logic [2:0]          sh1 [COLS];
  logic [2:0]          sh0_n [COLS];
  logic [2:0]          sh1_n [COLS];
  logic [2:0]          hold0 [COLS];
  logic [2:0]          hold1 [COLS];
  logic [SCW-1:0]      shift_cnt, cnt_n;
  logic [15:0]         noe_cnt;
  logic [CW-1:0]       col, col_nx;
  logic                bot;
  state_t              state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {LP_CLK, LATCH, NOE, ROW, RGB0, RGB1};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {lp_s, latch_s, noe_s, row_s, rgb0_s, rgb1_s} = sync_q[SYNC_STAGES-1];
  assign lp_rise    = lp_s & ~lp_d;
  assign latch_rise = latch_s & ~latch_d;
  assign col_nx     = col + 1'b1;
  assign bot        = (state == EMIT_BOT);

  // Shift results are formed combinationally so a same-cycle LATCH captures the new column.
  always_comb begin
    sh0_n = sh0;
    sh1_n = sh1;
    cnt_n = shift_cnt;
    if (lp_rise) begin
      if (shift_cnt < COLS_C) begin
        sh0_n[shift_cnt[CW-1:0]] = rgb0_s;
        sh1_n[shift_cnt[CW-1:0]] = rgb1_s;
      end
      if (shift_cnt != SAT_C) cnt_n = shift_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lp_d      <= 1'b0;
      latch_d   <= 1'b0;
      shift_cnt <= '0;
      noe_cnt   <= '0;
      oe_cycles <= '0;
      row_l     <= '0;
      col       <= '0;
      state     <= IDLE;
      pix_valid <= 1'b0;
      pix_addr  <= '0;
      pix_rgb   <= '0;
      line_done <= 1'b0;
      shift_err <= 1'b0;
      overrun   <= 1'b0;
      for (int unsigned i = 0; i < COLS; i++) begin
        sh0[i]   <= '0;
        sh1[i]   <= '0;
        hold0[i] <= '0;
        hold1[i] <= '0;
      end
    end else begin
      lp_d      <= lp_s;
      latch_d   <= latch_s;
      line_done <= 1'b0;
      shift_err <= 1'b0;
      overrun   <= 1'b0;
      sh0       <= sh0_n;
      sh1       <= sh1_n;
      shift_cnt <= cnt_n;
      if (!noe_s && noe_cnt != '1) noe_cnt <= noe_cnt + 1'b1;

      if (latch_rise) begin
        shift_cnt <= '0;
        oe_cycles <= noe_cnt;
        noe_cnt   <= '0;
        shift_err <= (cnt_n != COLS_C);
        if (state == IDLE) begin
          hold0 <= sh0_n;
          hold1 <= sh1_n;
          row_l <= row_s;
          col   <= '0;
          state <= EMIT_TOP;
        end else begin
          overrun <= 1'b1;
        end
      end

      case (state)
        EMIT_TOP, EMIT_BOT: begin
          if (!pix_valid) begin
            pix_valid <= 1'b1;
            pix_addr  <= {1'b0, row_l, col};
            pix_rgb   <= hold0[col];
          end else if (pix_ready) begin
            if (col == LAST_COL) begin
              col <= '0;
              if (!bot) begin
                state    <= EMIT_BOT;
                pix_addr <= {1'b1, row_l, {CW{1'b0}}};
                pix_rgb  <= hold1[0];
              end else begin
                state     <= IDLE;
                pix_valid <= 1'b0;
                line_done <= 1'b1;
              end
            end else begin
              col      <= col_nx;
              pix_addr <= {bot, row_l, col_nx};
              pix_rgb  <= bot ? hold1[col_nx] : hold0[col_nx];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_hub75_panel_rx.sv
// Directed bench for hub75_panel_rx: a line-level model predicts every pixel
// write and pulse; a negedge monitor compares the DUT against it each cycle.
module tb_hub75_panel_rx;
  localparam int COLS = 64;
  localparam int ROW_BITS = 5;
  localparam int SYNC = 2;

  logic        clk = 1'b0, rst = 1'b1;
  logic        LP_CLK = 1'b0, LATCH = 1'b0, NOE = 1'b1;
  logic [4:0]  ROW = '0;
  logic [2:0]  RGB0 = '0, RGB1 = '0;
  logic        pix_ready = 1'b0;
  logic        pix_valid, line_done, shift_err, overrun;
  logic [11:0] pix_addr;
  logic [2:0]  pix_rgb;
  logic [15:0] oe_cycles;

  always #5 clk = ~clk;

  hub75_panel_rx #(.COLS(COLS), .ROW_BITS(ROW_BITS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .LP_CLK(LP_CLK), .LATCH(LATCH), .NOE(NOE), .ROW(ROW),
    .RGB0(RGB0), .RGB1(RGB1), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_addr(pix_addr), .pix_rgb(pix_rgb), .line_done(line_done),
    .shift_err(shift_err), .overrun(overrun), .oe_cycles(oe_cycles)
  );

  int errors = 0, checks = 0;
  logic [2:0]  m0 [COLS];
  logic [2:0]  m1 [COLS];
  int          mp = 0;
  logic [11:0] qa[$];
  logic [2:0]  qr[$];
  int exp_ld = 0, exp_se = 0, exp_ov = 0;
  int cnt_ld = 0, cnt_se = 0, cnt_ov = 0;
  int n_acc = 0, n_row9 = 0, cyc = 0, rise_cyc = -1, lat_cyc = 0;
  int ready_mode = 0;
  logic ready_val = 1'b0;
  logic stall_prev = 1'b0, prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [2:0] pat(input int p, input int c, input bit b);
    logic [2:0] v;
    v = c[2:0];
    case (p)
      0:       return b ? ~v : v;
      1:       return b ? v : ~v;
      default: return b ? 3'b010 : 3'b101;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pulses(input logic [4:0] row, input int n, input int p);
    ROW = row;
    for (int k = 0; k < n; k++) begin
      RGB0 = pat(p, mp, 1'b0);
      RGB1 = pat(p, mp, 1'b1);
      LP_CLK = 1'b0;
      tick(2);
      LP_CLK = 1'b1;
      tick(2);
      if (mp < COLS) begin
        m0[mp] = RGB0;
        m1[mp] = RGB1;
      end
      mp++;
    end
    LP_CLK = 1'b0;
  endtask

  task automatic latch_start();
    lat_cyc = cyc;
    LATCH = 1'b1;
    if (mp != COLS) exp_se++;
    if (qa.size() != 0) exp_ov++;
    else begin
      for (int h = 0; h < 2; h++)
        for (int c = 0; c < COLS; c++) begin
          qa.push_back({h[0], ROW, c[5:0]});
          qr.push_back(h == 1 ? m1[c] : m0[c]);
        end
      exp_ld++;
    end
    mp = 0;
  endtask

  task automatic latch_end();
    tick(4);
    LATCH = 1'b0;
    tick(2);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && qa.size() != 0; i++) tick(1);
    if (qa.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pixels pending expected 0", qa.size());
    end
    tick(4);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) check("stall_valid", 32'(pix_valid), 32'd1);
      if (pix_valid && !prev_valid) rise_cyc = cyc;
      if (line_done) begin
        cnt_ld++;
        check("line_done_last", 32'(qa.size()), 32'd0);
      end
      if (shift_err) cnt_se++;
      if (overrun) cnt_ov++;
      if (pix_valid) begin
        if (qa.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_write: got addr %0d rgb %0d expected no write", pix_addr, pix_rgb);
        end else begin
          check("pix_addr", 32'(pix_addr), 32'(qa[0]));
          check("pix_rgb", 32'(pix_rgb), 32'(qr[0]));
          if (pix_ready) begin
            n_acc++;
            if (pix_addr[10:6] == 5'd9) n_row9++;
            void'(qa.pop_front());
            void'(qr.pop_front());
          end
        end
      end
      stall_prev = pix_valid && !pix_ready;
      prev_valid = pix_valid;
    end else begin
      stall_prev = 1'b0;
      prev_valid = 1'b0;
    end
  end

  initial begin
    int base;
    for (int i = 0; i < COLS; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(posedge clk);
        #1;
        pix_ready = (ready_mode != 0) ? ~pix_ready : ready_val;
      end
    join_none

    tick(3);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_addr", 32'(pix_addr), 32'd0);
    check("rst_rgb", 32'(pix_rgb), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_shift_err", 32'(shift_err), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_oe_cycles", 32'(oe_cycles), 32'd0);
    rst = 1'b0;
    tick(3);

    // T1 basic
    ready_val = 1'b1;
    send_pulses(5'd5, 64, 0);
    latch_start();
    check("model_first_addr", 32'(qa[0]), 32'd320);
    check("model_last_addr", 32'(qa[127]), 32'd2431);
    check("model_top_c63", 32'(qr[63]), 32'd7);
    check("model_bot_c0", 32'(qr[64]), 32'd7);
    check("model_bot_c63", 32'(qr[127]), 32'd0);
    latch_end();
    check("latch_latency", 32'(rise_cyc - lat_cyc), 32'(SYNC + 2));
    drain();
    check("t1_line_done", 32'(cnt_ld), 32'd1);
    check("t1_shift_err", 32'(cnt_se), 32'd0);

    // T2 backpressure
    ready_mode = 1;
    send_pulses(5'd5, 64, 0);
    latch_start();
    latch_end();
    drain();
    ready_mode = 0;
    check("t2_line_done", 32'(cnt_ld), 32'd2);

    // T3 short line
    send_pulses(5'd5, 63, 1);
    latch_start();
    check("model_stale_top", 32'(qr[63]), 32'd7);
    check("model_stale_bot", 32'(qr[127]), 32'd0);
    check("model_t3_c62", 32'(qr[62]), 32'd1);
    latch_end();
    drain();
    check("t3_shift_err", 32'(cnt_se), 32'd1);

    // T4 overrun
    ready_val = 1'b0;
    tick(2);
    send_pulses(5'd5, 64, 0);
    latch_start();
    latch_end();
    tick(10);
    send_pulses(5'd9, 64, 2);
    latch_start();
    latch_end();
    ready_val = 1'b1;
    drain();
    check("t4_overrun", 32'(cnt_ov), 32'd1);
    check("t4_row9_writes", 32'(n_row9), 32'd0);
    check("t4_line_done", 32'(cnt_ld), 32'd4);

    // T5 NOE measurement
    send_pulses(5'd3, 64, 0);
    latch_start();
    latch_end();
    NOE = 1'b0;
    tick(1000);
    NOE = 1'b1;
    send_pulses(5'd3, 64, 1);
    latch_start();
    latch_end();
    check("oe_cycles_1000", 32'(oe_cycles), 32'd1000);
    send_pulses(5'd3, 64, 0);
    latch_start();
    latch_end();
    check("oe_cycles_restart", 32'(oe_cycles), 32'd0);
    drain();

    // T6 reset mid-emission
    send_pulses(5'd7, 64, 0);
    base = n_acc;
    latch_start();
    latch_end();
    for (int i = 0; i < 200 && n_acc < base + 10; i++) tick(1);
    rst = 1'b1;
    #1;
    check("t6_valid_drop", 32'(pix_valid), 32'd0);
    check("t6_line_done", 32'(line_done), 32'd0);
    qa.delete();
    qr.delete();
    exp_ld--;
    mp = 0;
    for (int i = 0; i < COLS; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    tick(2);
    rst = 1'b0;
    base = n_acc;
    tick(20);
    check("t6_no_writes", 32'(n_acc - base), 32'd0);
    check("t6_idle_valid", 32'(pix_valid), 32'd0);
    send_pulses(5'd7, 64, 1);
    latch_start();
    latch_end();
    drain();

    check("total_line_done", 32'(cnt_ld), 32'(exp_ld));
    check("total_shift_err", 32'(cnt_se), 32'(exp_se));
    check("total_overrun", 32'(cnt_ov), 32'(exp_ov));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
